// File: rtl/uart_pkg.sv
// Shared frame constants and FSM encoding for the txuart/rxuart pair, so both
// ends of the serial link agree on bit timing and frame shape.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    // start + 8 data + stop; parity adds one more bit when enabled
    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int frame_bits(input bit parity_en);
        return FRAME_BITS + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/txuart_if.sv
// Write-side port of the transmitter: one-cycle write strobe with byte, plus
// buffer full/empty status back to the producer.
interface txuart_if;
    import uart_pkg::*;

    // i_wr is a one-cycle strobe; the byte is taken only when o_full is low in
    // that same cycle, otherwise it is dropped and the producer must retry.
    logic                 i_wr;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_full;
    logic                 o_empty;

    modport master (
        output i_wr,
        output i_data,
        input  o_full,
        input  o_empty
    );

    modport slave (
        input  i_wr,
        input  i_data,
        output o_full,
        output o_empty
    );

endinterface

// File: rtl/txuart_fifo.sv
// Circular byte buffer between the write port and the serializer; pointers wrap
// naturally and full/empty are decoded from a registered occupancy count.
module txuart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic wr_en;
    logic rd_en;

    assign o_full  = (count_q == FULL_COUNT);
    assign o_empty = (count_q == '0);
    assign wr_en   = i_wr && !o_full;
    assign rd_en   = i_rd && !o_empty;
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while the count says empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= i_data;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        count_q <= FULL_COUNT);

endmodule

// File: rtl/txuart.sv
// 8N1 (optionally even-parity) UART transmitter fed from a small write buffer;
// back-to-back bytes are sent with no idle bit between stop and next start.
module txuart
    import uart_pkg::*;
#(
    parameter int clkFreq   = 25000000,
    parameter int baudRate  = 115200,
    parameter bit if_parity = 1'b0,
    parameter int fifoDepth = 8
) (
    input  logic        clk,
    input  logic        rstn,
    txuart_if.slave     wr_if,
    output logic        o_busy,
    output logic        o_uart_tx,
    output uart_state_e o_state
);

    localparam int CPB = clks_per_bit(clkFreq, baudRate);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

    uart_state_e state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 pop;
    logic                 bit_end;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    txuart_fifo #(
        .DEPTH (fifoDepth),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_wr    (wr_if.i_wr),
        .i_data  (wr_if.i_data),
        .i_rd    (pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign wr_if.o_full  = fifo_full;
    assign wr_if.o_empty = fifo_empty;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        // Every state change happens at a bit end or out of IDLE, so this also
        // clears the counter on each state entry.
        baud_d  = (state_q != ST_IDLE && !bit_end) ? baud_q + 1'b1 : '0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = if_parity ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shift_d = fifo_data;
            par_d   = ^fifo_data;
        end

        // Line level follows the next state so tx is registered with no lag.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;
    assign o_state   = state_q;

    a_idle_baud_clear: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_IDLE) |-> (baud_q == '0));

endmodule

// File: tb/tb_txuart.sv
// Bench for txuart: one instance without parity and one with even parity,
// driven by directed frame vectors plus multi-cycle buffer/reset sequences.
module tb_txuart;
    import uart_pkg::*;

    localparam int CPB = 217;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    txuart_if if0();
    txuart_if if1();

    logic        tx0, tx1, busy0, busy1;
    uart_state_e st0, st1;

    logic        sel   = 1'b0;
    logic        wr    = 1'b0;
    logic [7:0]  wdata = 8'h00;

    assign if0.i_wr   = wr & ~sel;
    assign if1.i_wr   = wr & sel;
    assign if0.i_data = wdata;
    assign if1.i_data = wdata;

    txuart #(.clkFreq(25000000), .baudRate(115200), .if_parity(1'b0), .fifoDepth(8)) dut0 (
        .clk(clk), .rstn(rstn), .wr_if(if0), .o_busy(busy0), .o_uart_tx(tx0), .o_state(st0)
    );
    txuart #(.clkFreq(25000000), .baudRate(115200), .if_parity(1'b1), .fifoDepth(8)) dut1 (
        .clk(clk), .rstn(rstn), .wr_if(if1), .o_busy(busy1), .o_uart_tx(tx1), .o_state(st1)
    );

    logic        cur_tx, cur_busy, cur_empty, cur_full;
    uart_state_e cur_st;
    always_comb begin
        cur_tx    = sel ? tx1 : tx0;
        cur_busy  = sel ? busy1 : busy0;
        cur_empty = sel ? if1.o_empty : if0.o_empty;
        cur_full  = sel ? if1.o_full : if0.o_full;
        cur_st    = sel ? st1 : st0;
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check_bit(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_burst(input logic [7:0] first, input int n, input logic [7:0] step);
        logic [7:0] d;
        d = first;
        @(negedge clk);
        wr = 1'b1;
        for (int i = 0; i < n; i++) begin
            wdata = d;
            @(negedge clk);
            d = d + step;
        end
        wr = 1'b0;
    endtask

    // Called on the first cycle of the start bit; checks every cycle of every bit.
    task automatic check_frame(input logic [10:0] bits, input int nbits,
                               input bit end_idle, input string tag);
        int bad_tx;
        int bad_busy;
        for (int b = 0; b < nbits; b++) begin
            bad_tx   = 0;
            bad_busy = 0;
            for (int c = 0; c < CPB; c++) begin
                if (cur_tx !== bits[b]) bad_tx++;
                if (cur_busy !== 1'b1) bad_busy++;
                @(negedge clk);
            end
            check_int($sformatf("%s_bit%0d_tx_bad_cycles", tag, b), bad_tx, 0);
            check_int($sformatf("%s_bit%0d_busy_bad_cycles", tag, b), bad_busy, 0);
        end
        if (end_idle) begin
            check_bit({tag, "_idle_tx"}, cur_tx, 1'b1);
            check_bit({tag, "_idle_busy"}, cur_busy, 1'b0);
            check_int({tag, "_idle_state"}, int'(cur_st), int'(ST_IDLE));
        end
    endtask

    // Mid-bit sampling receiver for the non-parity instance.
    task automatic recv_byte(output logic [7:0] d, output bit ok, output logic empty_at_start);
        int waited;
        waited = 0;
        ok = 1'b1;
        d = 8'h00;
        empty_at_start = 1'bx;
        while (cur_tx !== 1'b0 && waited < 4 * CPB) begin
            @(negedge clk);
            waited++;
        end
        if (cur_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        empty_at_start = cur_empty;
        repeat (CPB / 2) @(negedge clk);
        if (cur_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = cur_tx;
        end
        repeat (CPB) @(negedge clk);
        if (cur_tx !== 1'b1) ok = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        sel;
        logic [7:0]  data;
        logic [10:0] bits;   // bit i = i-th line level, start bit first
        int          nbits;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    initial begin
        logic [7:0] got;
        bit         ok;
        logic       emp;
        int         lows;
        int         busys;

        vecs[0] = '{1'b0, 8'h41, 11'h282, 10};
        vecs[1] = '{1'b0, 8'h00, 11'h200, 10};
        vecs[2] = '{1'b0, 8'h55, 11'h2AA, 10};
        vecs[3] = '{1'b1, 8'h07, 11'h60E, 11};
        vecs[4] = '{1'b1, 8'h03, 11'h406, 11};
        vecs[5] = '{1'b1, 8'hFF, 11'h5FE, 11};

        rstn = 1'b0;
        repeat (4) @(negedge clk);
        check_bit("rst_tx0_low", tx0, 1'b1);
        rstn = 1'b1;
        @(negedge clk);

        check_bit("rst_tx0", tx0, 1'b1);
        check_bit("rst_busy0", busy0, 1'b0);
        check_bit("rst_empty0", if0.o_empty, 1'b1);
        check_bit("rst_full0", if0.o_full, 1'b0);
        check_int("rst_state0", int'(st0), int'(ST_IDLE));
        check_bit("rst_tx1", tx1, 1'b1);
        check_bit("rst_busy1", busy1, 1'b0);
        check_bit("rst_empty1", if1.o_empty, 1'b1);
        check_bit("rst_full1", if1.o_full, 1'b0);

        // single frames
        for (int v = 0; v < NV; v++) begin
            sel = vecs[v].sel;
            write_burst(vecs[v].data, 1, 8'h00);
            check_bit($sformatf("v%0d_tx_before_start", v), cur_tx, 1'b1);
            check_bit($sformatf("v%0d_not_empty", v), cur_empty, 1'b0);
            @(negedge clk);
            check_bit($sformatf("v%0d_empty_after_pop", v), cur_empty, 1'b1);
            check_frame(vecs[v].bits, vecs[v].nbits, 1'b1, $sformatf("v%0d", v));
        end

        // back-to-back 0x55, 0xAA: second start directly after first stop
        sel = 1'b0;
        write_burst(8'h55, 2, 8'h55);
        check_frame(11'h2AA, 10, 1'b0, "b2b0");
        check_frame(11'h354, 10, 1'b1, "b2b1");

        // overflow: 10 writes on consecutive cycles, 10th dropped
        @(negedge clk);
        wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata = 8'h10 + 8'(i);
            @(negedge clk);
            if (i >= 7) check_bit($sformatf("ovf_full_after_w%0d", i + 1), if0.o_full, (i >= 8));
            if (i < 9) exp_q.push_back(wdata);
        end
        wr = 1'b0;
        for (int k = 0; k < 9; k++) begin
            recv_byte(got, ok, emp);
            check_bit($sformatf("ovf_frame%0d_ok", k), ok, 1'b1);
            check_int($sformatf("ovf_frame%0d_data", k), int'(got), int'(exp_q.pop_front()));
            check_bit($sformatf("ovf_frame%0d_empty", k), emp, (k == 8));
        end
        repeat (CPB) @(negedge clk);
        check_bit("ovf_end_tx", tx0, 1'b1);
        check_bit("ovf_end_busy", busy0, 1'b0);
        check_bit("ovf_end_empty", if0.o_empty, 1'b1);
        check_int("ovf_queue_left", exp_q.size(), 0);

        // write landing in the stop->start pop cycle with 7 bytes buffered
        write_burst(8'h20, 8, 8'h01);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h20 + 8'(i));
        check_bit("simul_full_at7", if0.o_full, 1'b0);
        repeat (10 * CPB - 7) @(negedge clk);
        check_int("simul_last_stop_state", int'(st0), int'(ST_STOP));
        wr = 1'b1;
        wdata = 8'h30;
        exp_q.push_back(8'h30);
        @(negedge clk);
        wr = 1'b0;
        check_int("simul_restart_state", int'(st0), int'(ST_START));
        check_bit("simul_restart_tx", tx0, 1'b0);
        check_bit("simul_full_kept_low", if0.o_full, 1'b0);
        wr = 1'b1;
        wdata = 8'h31;
        exp_q.push_back(8'h31);
        @(negedge clk);
        wr = 1'b0;
        check_bit("simul_full_after_extra", if0.o_full, 1'b1);
        for (int k = 0; k < 9; k++) begin
            recv_byte(got, ok, emp);
            check_bit($sformatf("simul_frame%0d_ok", k), ok, 1'b1);
            check_int($sformatf("simul_frame%0d_data", k), int'(got), int'(exp_q.pop_front()));
        end
        repeat (CPB) @(negedge clk);
        check_bit("simul_end_busy", busy0, 1'b0);

        // reset during data bit 3 with two bytes still buffered
        write_burst(8'h00, 3, 8'h00);
        repeat (4 * CPB + 20) @(negedge clk);
        check_int("mid_state_data", int'(st0), int'(ST_DATA));
        check_bit("mid_tx_low", tx0, 1'b0);
        check_bit("mid_empty_before", if0.o_empty, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check_bit("mid_rst_tx", tx0, 1'b1);
        check_bit("mid_rst_busy", busy0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_bit("mid_post_empty", if0.o_empty, 1'b1);
        check_bit("mid_post_full", if0.o_full, 1'b0);
        lows  = 0;
        busys = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            if (tx0 !== 1'b1) lows++;
            if (busy0 !== 1'b0) busys++;
            @(negedge clk);
        end
        check_int("mid_post_tx_low_cycles", lows, 0);
        check_int("mid_post_busy_cycles", busys, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/txuart.md
# txuart

Byte-wide UART transmitter with an 8-entry write buffer. It sends game status bytes (square position, hole-hit events, echoed key codes) back to the PC over the same serial link whose receive side carries the keyboard commands. It sits in the `clk` domain next to `rxuart` and shares its frame format: 8N1, with optional even parity.

## Interface
- `clkFreq`, 25000000: `clk` frequency in Hz.
- `baudRate`, 115200: line rate in baud.
- `if_parity`, 1'b0: 1 inserts an even-parity bit after the data bits.
- `fifoDepth`, 8: buffer entries. Must be a power of two, ≥2.

- `clk`  in  1  system clock. All logic is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_wr`  in  1  write strobe, one cycle per byte.
- `i_data`  in  8  byte to send, sampled when `i_wr`=1.
- `o_full`  out  1  buffer holds `fifoDepth` bytes.
- `o_empty`  out  1  buffer holds 0 bytes.
- `o_busy`  out  1  a frame is in progress (state ≠ IDLE).
- `o_uart_tx`  out  1  serial line, idles high.

## Operation
- CLKS_PER_BIT = clkFreq/baudRate, using integer division: 217 at the defaults. Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- Write acceptance:
  - A write is accepted only if `o_full`=0 in that cycle.
  - A write while full is dropped silently, and buffer contents are unchanged.
  - A write and a pop in the same cycle are both honoured when not full, and the count is unchanged.
- Byte order: LSB first.
- Frame: start(0), d0..d7, [parity = ^data], stop(1). That is 10 bits, or 11 with parity.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the buffer is non-empty, pop the head byte into the shift register → START.
  - START: tx=0 for CLKS_PER_BIT → DATA with bit index 0.
  - DATA: tx=shift[0]. At each bit end, shift right and increment the 3-bit index. After index 7, go → PARITY if `if_parity`, else → STOP.
  - PARITY: tx=parity for CLKS_PER_BIT → STOP.
  - STOP: tx=1 for CLKS_PER_BIT. At its end: if the buffer is non-empty, pop → START directly, with no idle bit. Else → IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Is cleared on every state entry.
  - Bit end is the cycle with counter = CLKS_PER_BIT-1.
- Buffer: circular, with log2(fifoDepth)-bit pointers plus a count of width log2(fifoDepth)+1. Pointers wrap naturally.
- Reset values: `o_uart_tx`=1, `o_busy`=0, `o_empty`=1, `o_full`=0. State=IDLE. Pointers, count, baud counter and index are all 0.
- Reset mid-frame: the line returns high immediately (asynchronously). The partial frame is abandoned and buffered bytes are discarded.

## Timing
- `o_uart_tx` and `o_busy` are registered outputs. `o_full` and `o_empty` are registered, or decoded from the registered count.
- Write at edge N into an idle, empty block:
  - The count becomes 1 after edge N.
  - Pop and START happen at edge N+1, so `o_uart_tx` falls after edge N+1.
  - `o_empty` is high again after edge N+1.
- Stop bit to next start: the next start bit begins the cycle right after the stop bit's last cycle.
- Frame durations:
  - Single-byte frame occupancy: 10×CLKS_PER_BIT cycles, i.e. 2170 at the defaults.
  - Back-to-back frames: exactly 10×CLKS_PER_BIT cycles per byte.
- `o_busy` falls in the cycle after the last stop-bit cycle, and only if the buffer is empty.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (3 bits).
  - The CLKS_PER_BIT computation.
  - The frame-length constant.
  - `rxuart` also uses this package, so both ends stay consistent.
- One sub-module, `txuart_fifo`. It is a synchronous circular buffer: write/read strobes, `i_data`/`o_data`, `o_full`/`o_empty`, async reset. The serializer FSM stays in `txuart`.

## Test plan
- Single byte, defaults. Write 0x41 → line reads 0,1,0,0,0,0,0,1,0,1. Each level lasts 217 cycles, the start edge is 1 cycle after the write, and `o_busy` is high for 2170 cycles.
- Overflow. Write 10 consecutive cycles into an empty idle block → `o_full` is set after the 9th write. The 10th byte is dropped, 9 frames are sent in order, and `o_empty`=1 after the 9th pop.
- Back-to-back. Write 0x55 then 0xAA → the second start bit directly follows the first stop bit. The total low-to-idle span is 4340 cycles, and `o_busy` stays high throughout.
- Parity. Set `if_parity`=1 and send 0x07 → the parity bit is 1 and the frame is 11 bits (2387 cycles). Sending 0x03 gives a parity bit of 0.
- Reset mid-frame. Assert `rstn`=0 during DATA bit 3 with 2 bytes buffered → tx=1 and `o_busy`=0 immediately. After release, `o_empty`=1 and no frame starts.
- Simultaneous write/pop at full-minus-one. Have 7 bytes buffered; a write lands in the STOP→START pop cycle → the count stays 7, the byte is accepted, and `o_full` stays 0.
